digit_bbox_detect: RTL and testbench
====================================

# digit_bbox_detect

Upstream stage of `digital_recognition`. Scans one binarized 640×480 frame in raster order and finds the bounding box of the foreground digit: top, bottom, left and right edges. A run-length filter rejects isolated noise pixels. At end of frame the block latches the edges in the packed `{far, near}` format that `digital_recognition` takes on `iEdge_Row` and `iEdge_Col`, and pulses a valid strobe.

## Interface
Parameters:
- `H_ACT`, 640, active columns per line.
- `V_ACT`, 480, active lines per frame.
- `THRESH`, 10'd512, a pixel is foreground when `iBWData < THRESH`, so black ink is foreground.
- `MIN_RUN`, 3, minimum consecutive foreground pixels on one line before any of them counts (1..15).

Ports:
- `clk`  in  1  system clock. One clock domain.
- `rst`  in  1  reset, synchronous and active-low.
- `en`  in  1  enable. Low aborts any scan in progress.
- `iRow`  in  10  current pixel line index.
- `iCol`  in  10  current pixel column index.
- `iBWData`  in  10  binarized pixel (10'h3FF white, 10'h000 black).
- `oEdge_Row`  out  20  `{bottom, top}` line indices.
- `oEdge_Col`  out  20  `{right, left}` column indices.
- `oFound`  out  1  the last completed frame contained qualified foreground.
- `oValid`  out  1  one-cycle pulse when `oEdge_*` and `oFound` update.

## Operation
- All inputs are sampled on the rising edge of `clk`. A pixel is "in frame" when `iRow < V_ACT` and `iCol < H_ACT`; all other pixels are ignored.
- State machine, states IDLE, SCAN, DONE:
  - IDLE: wait for a sampled pixel at (0,0) with `en=1`.
    - On that pixel, initialise `top = V_ACT-1`, `bottom = 0`, `left = H_ACT-1`, `right = 0`, `hit = 0`.
    - Process the pixel, then go to SCAN.
  - SCAN: process each in-frame pixel.
    - On the pixel (V_ACT-1, H_ACT-1), go to DONE.
    - `en=0` goes to IDLE; accumulators are discarded and outputs are unchanged.
  - DONE: lasts one cycle.
    - Latch outputs and assert `oValid`.
    - Go to IDLE. If that cycle's sample is (0,0) with `en=1`, it is treated as a new frame start and goes straight to SCAN instead.
- Run filter:
  - `run` is a 4-bit saturating counter.
  - `run` is cleared at `iCol == 0` before evaluating that pixel.
  - A foreground pixel increments `run`; a background pixel clears it.
  - A pixel at column c is "qualified" when the updated `run >= MIN_RUN`.
- Edge update on a qualified pixel at (r, c):
  - `top = min(top, r)` and `bottom = max(bottom, r)`.
  - `left = min(left, c - MIN_RUN + 1)`; evaluate this only when `run == MIN_RUN`, i.e. at the start of the run.
  - `right = max(right, c)`.
  - Set `hit = 1`.
- Latch in DONE:
  - If `hit = 1`: `oEdge_Row = {bottom, top}`, `oEdge_Col = {right, left}`, `oFound = 1`.
  - If `hit = 0`: `oEdge_Row = 0`, `oEdge_Col = 0`, `oFound = 0`.
- Arithmetic is 10-bit unsigned. `c - MIN_RUN + 1` cannot underflow, because qualification implies `c >= MIN_RUN - 1`.

## Timing
- Reset values: `oEdge_Row = 0`, `oEdge_Col = 0`, `oFound = 0`, `oValid = 0`, state IDLE, `run = 0`.
- Latency: `oValid` is high for exactly the cycle after the edge on which (V_ACT-1, H_ACT-1) is sampled. `oEdge_*` and `oFound` change on that same edge and hold until the next `oValid`.
- Reset or `en=0` mid-frame:
  - No `oValid` for that frame.
  - The next valid frame needs a fresh (0,0).
  - Reset clears all outputs; `en=0` does not.
- Simultaneous events:
  - A qualified pixel on the final coordinate is included in the latched result.
  - `en=0` on the final pixel aborts the frame.
- Repeated coordinates (e.g. a stalled source) are processed again. The source is required to present each pixel once.
- Throughput: one pixel per clock, no backpressure.

## Structure
- Package `digit_pkg`:
  - `COORD_W = 10`, `H_ACT_DEF = 640`, `V_ACT_DEF = 480`.
  - typedef `coord_t` (10 bits).
  - typedef `edge_pair_t` as a packed `{coord_t far, coord_t near}`, shared with `digital_recognition`.
  - State enum `bbox_state_e`.
- Sub-module `bw_run_filter` contains the threshold compare, the run counter and the qualified/run-start flags. It takes `iCol`, `iBWData` and an in-frame flag.
- The top level holds the FSM, the four min/max accumulators and the output registers.

## Test plan
- Black rectangle at lines 77..232, columns 74..159, on a white frame → `oValid` one cycle after (479,639), with `oEdge_Row = {232,77}`, `oEdge_Col = {159,74}`, `oFound = 1`.
- All-white frame → `oFound = 0`, `oEdge_Row = 0`, `oEdge_Col = 0`, `oValid` pulses once.
- Rectangle from the test above plus 2-pixel black specks at (10,600) and (400,5), with MIN_RUN=3 → edges are unchanged from the rectangle-only result.
- Black run spanning columns 0..639 on line 479 only → `oEdge_Row = {479,479}`, `oEdge_Col = {639,0}`.
- Rectangle frame with `rst` low at (200,300), then released before the next (0,0) → no `oValid` for the aborted frame; the next frame reports `{232,77}` / `{159,74}`.
- `en` low for one cycle mid-frame → no `oValid` and outputs hold the previous frame's values. Two back-to-back full frames with `en=1` give two `oValid` pulses exactly 307200 cycles apart.

Source files
------------

// File: rtl/digit_pkg.sv
// digit_pkg: shared types for the digit bounding-box front end.
//   COORD_W            width of a pixel line/column index
//   H_ACT_DEF/V_ACT_DEF default active frame size
//   coord_t            one line or column index
//   edge_pair_t        packed {far, near} edge pair, the layout the
//                      downstream recogniser takes on its edge inputs
//   bbox_state_e       scan state machine encoding
package digit_pkg;
  localparam int COORD_W   = 10;
  localparam int H_ACT_DEF = 640;
  localparam int V_ACT_DEF = 480;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t far;
    coord_t near;
  } edge_pair_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } bbox_state_e;
endpackage

// File: rtl/bw_run_filter.sv
// bw_run_filter: per-line run-length filter on the binarized pixel stream.
//   clk, rst      clock, synchronous active-low reset
//   in_frame      current pixel lies inside the active window
//   iCol          current pixel column
//   iBWData       binarized pixel, foreground when below THRESH
//   qual          this pixel is part of a run at least MIN_RUN long
//   run_start     this pixel is the one that just made the run qualify
module bw_run_filter
  import digit_pkg::*;
#(
  parameter logic [9:0] THRESH  = 10'd512,
  parameter int         MIN_RUN = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_frame,
  input  logic [COORD_W-1:0] iCol,
  input  logic [9:0]         iBWData,
  output logic               qual,
  output logic               run_start
);

  logic [3:0] run_q, run_base, run_nxt;
  logic       fg;

  assign fg = iBWData < THRESH;

  always_comb begin
    // column 0 starts a fresh line, so a run never wraps across lines
    run_base = (iCol == '0) ? 4'd0 : run_q;
    if (!fg)
      run_nxt = 4'd0;
    else if (run_base == 4'hF)
      run_nxt = 4'hF;
    else
      run_nxt = run_base + 4'd1;
  end

  // background forces run_nxt to 0, and MIN_RUN >= 1, so qual implies fg
  assign qual      = run_nxt >= 4'(MIN_RUN);
  assign run_start = run_nxt == 4'(MIN_RUN);

  always_ff @(posedge clk) begin
    if (!rst)
      run_q <= 4'd0;
    else if (in_frame)
      run_q <= run_nxt;
  end

endmodule

// File: rtl/digit_bbox_detect.sv
// digit_bbox_detect: scans one binarized frame in raster order and reports
// the bounding box of run-filtered foreground at end of frame.
//   clk, rst        clock, synchronous active-low reset
//   en              enable; low aborts a scan in progress
//   iRow, iCol      coordinate of the current pixel
//   iBWData         binarized pixel (3FF white, 000 black)
//   oEdge_Row       {bottom, top} of the last completed frame
//   oEdge_Col       {right, left} of the last completed frame
//   oFound          last completed frame held qualified foreground
//   oValid          one-cycle strobe when the outputs above update
module digit_bbox_detect
  import digit_pkg::*;
#(
  parameter int         H_ACT   = H_ACT_DEF,
  parameter int         V_ACT   = V_ACT_DEF,
  parameter logic [9:0] THRESH  = 10'd512,
  parameter int         MIN_RUN = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [COORD_W-1:0]   iRow,
  input  logic [COORD_W-1:0]   iCol,
  input  logic [9:0]           iBWData,
  output logic [2*COORD_W-1:0] oEdge_Row,
  output logic [2*COORD_W-1:0] oEdge_Col,
  output logic                 oFound,
  output logic                 oValid
);

  localparam coord_t ROW_LAST = coord_t'(V_ACT - 1);
  localparam coord_t COL_LAST = coord_t'(H_ACT - 1);

  bbox_state_e state, state_nxt;

  logic   in_frame, at_origin, at_last, start, proc, fin;
  logic   qual, run_start;
  coord_t top_q, bot_q, left_q, right_q;
  coord_t top_b, bot_b, left_b, right_b;
  coord_t top_n, bot_n, left_n, right_n;
  coord_t left_cand;
  logic   hit_q, hit_b, hit_n;
  edge_pair_t row_pair, col_pair;

  assign in_frame  = (iRow < coord_t'(V_ACT)) && (iCol < coord_t'(H_ACT));
  assign at_origin = (iRow == '0) && (iCol == '0);
  assign at_last   = (iRow == ROW_LAST) && (iCol == COL_LAST);

  // a frame may start either from IDLE or in the single DONE cycle
  assign start = en && at_origin && (state == ST_IDLE || state == ST_DONE);
  assign proc  = en && in_frame && (state == ST_SCAN || start);
  assign fin   = en && at_last && (state == ST_SCAN);

  bw_run_filter #(
    .THRESH  (THRESH),
    .MIN_RUN (MIN_RUN)
  ) u_filt (
    .clk       (clk),
    .rst       (rst),
    .in_frame  (in_frame),
    .iCol      (iCol),
    .iBWData   (iBWData),
    .qual      (qual),
    .run_start (run_start)
  );

  // ---- FSM: state register
  always_ff @(posedge clk) begin
    if (!rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // ---- FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (!en)
          state_nxt = ST_IDLE;
        else if (at_last)
          state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = start ? ST_SCAN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs
  always_comb begin
    oValid = (state == ST_DONE);
  end

  // ---- accumulators: frame start seeds them, then the pixel is folded in
  assign left_cand = iCol - coord_t'(MIN_RUN - 1);

  always_comb begin
    top_b   = start ? ROW_LAST : top_q;
    bot_b   = start ? '0       : bot_q;
    left_b  = start ? COL_LAST : left_q;
    right_b = start ? '0       : right_q;
    hit_b   = start ? 1'b0     : hit_q;

    top_n   = top_b;
    bot_n   = bot_b;
    left_n  = left_b;
    right_n = right_b;
    hit_n   = hit_b;

    if (proc && qual) begin
      if (iRow < top_b)   top_n = iRow;
      if (iRow > bot_b)   bot_n = iRow;
      // the run's first pixel is MIN_RUN-1 columns back from here
      if (run_start && (left_cand < left_b)) left_n = left_cand;
      if (iCol > right_b) right_n = iCol;
      hit_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      top_q   <= ROW_LAST;
      bot_q   <= '0;
      left_q  <= COL_LAST;
      right_q <= '0;
      hit_q   <= 1'b0;
    end else if (proc) begin
      top_q   <= top_n;
      bot_q   <= bot_n;
      left_q  <= left_n;
      right_q <= right_n;
      hit_q   <= hit_n;
    end
  end

  // ---- output latch: uses the folded values so a qualified final pixel counts
  always_comb begin
    row_pair.far  = bot_n;
    row_pair.near = top_n;
    col_pair.far  = right_n;
    col_pair.near = left_n;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      oEdge_Row <= '0;
      oEdge_Col <= '0;
      oFound    <= 1'b0;
    end else if (fin) begin
      oEdge_Row <= hit_n ? row_pair : '0;
      oEdge_Col <= hit_n ? col_pair : '0;
      oFound    <= hit_n;
    end
  end

endmodule

// File: tb/tb_digit_bbox_detect.sv
// Directed bench for digit_bbox_detect on a reduced 64x48 frame so several
// complete frames fit in a short run.
//   rectangle: lines 7..23, columns 9..20 -> rows {23,7}, cols {20,9}
//   specks:    2-pixel runs at (2,50..51) and (40,1..2), filtered out
//   line:      line 47 fully black -> rows {47,47}, cols {63,0}
module tb_digit_bbox_detect;
  localparam int H = 64;
  localparam int V = 48;
  localparam int FRAME = H * V;

  localparam logic [19:0] RECT_ROW = {10'd23, 10'd7};
  localparam logic [19:0] RECT_COL = {10'd20, 10'd9};
  localparam logic [19:0] LINE_ROW = {10'd47, 10'd47};
  localparam logic [19:0] LINE_COL = {10'd63, 10'd0};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b1;
  logic [9:0]  iRow = 10'h3FF;
  logic [9:0]  iCol = 10'h3FF;
  logic [9:0]  iBWData = 10'h3FF;
  logic [19:0] oEdge_Row, oEdge_Col;
  logic        oFound, oValid;

  digit_bbox_detect #(
    .H_ACT   (H),
    .V_ACT   (V),
    .THRESH  (10'd512),
    .MIN_RUN (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .iRow      (iRow),
    .iCol      (iCol),
    .iBWData   (iBWData),
    .oEdge_Row (oEdge_Row),
    .oEdge_Col (oEdge_Col),
    .oFound    (oFound),
    .oValid    (oValid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int npulse = 0;
  int vcyc_last = 0;
  int vcyc_prev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (oValid) begin
      npulse    <= npulse + 1;
      vcyc_prev <= vcyc_last;
      vcyc_last <= cyc;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic bit is_black(input int kind, input int r, input int c);
    bit rect;
    rect = (r >= 7) && (r <= 23) && (c >= 9) && (c <= 20);
    case (kind)
      1:       return rect;
      2:       return rect || (r == 2 && (c == 50 || c == 51)) ||
                              (r == 40 && (c == 1 || c == 2));
      3:       return r == 47;
      default: return 1'b0;
    endcase
  endfunction

  // one full frame, one pixel per clock; rst_at/en_at give the linear pixel
  // index where rst or en is pulled low for a single cycle (-1 = never)
  task automatic run_frame(input int kind, input int rst_at, input int en_at);
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) begin
        iRow    = 10'(r);
        iCol    = 10'(c);
        iBWData = is_black(kind, r, c) ? 10'h000 : 10'h3FF;
        rst     = (r * H + c == rst_at) ? 1'b0 : 1'b1;
        en      = (r * H + c == en_at)  ? 1'b0 : 1'b1;
        @(posedge clk);
        #1;
      end
    end
    rst = 1'b1;
    en  = 1'b1;
  endtask

  task automatic idle(input int n);
    iRow    = 10'h3FF;
    iCol    = 10'h3FF;
    iBWData = 10'h3FF;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int p0;

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_row",   32'(oEdge_Row), 32'd0);
    check("reset_col",   32'(oEdge_Col), 32'd0);
    check("reset_found", 32'(oFound),    32'd0);
    check("reset_valid", 32'(oValid),    32'd0);
    rst = 1'b1;
    idle(2);

    // rectangle
    p0 = npulse;
    run_frame(1, -1, -1);
    check("rect_valid",  32'(oValid),    32'd1);
    check("rect_row",    32'(oEdge_Row), 32'(RECT_ROW));
    check("rect_col",    32'(oEdge_Col), 32'(RECT_COL));
    check("rect_found",  32'(oFound),    32'd1);
    idle(1);
    check("rect_vdrop",  32'(oValid),    32'd0);
    check("rect_pulses", 32'(npulse - p0), 32'd1);

    // all white
    p0 = npulse;
    run_frame(0, -1, -1);
    check("white_valid", 32'(oValid),    32'd1);
    check("white_found", 32'(oFound),    32'd0);
    check("white_row",   32'(oEdge_Row), 32'd0);
    check("white_col",   32'(oEdge_Col), 32'd0);
    idle(1);
    check("white_pulses", 32'(npulse - p0), 32'd1);

    // rectangle plus short specks
    run_frame(2, -1, -1);
    check("speck_row",   32'(oEdge_Row), 32'(RECT_ROW));
    check("speck_col",   32'(oEdge_Col), 32'(RECT_COL));
    idle(1);

    // full last line: final pixel is qualified and must be included
    run_frame(3, -1, -1);
    check("line_valid",  32'(oValid),    32'd1);
    check("line_row",    32'(oEdge_Row), 32'(LINE_ROW));
    check("line_col",    32'(oEdge_Col), 32'(LINE_COL));
    idle(1);

    // reset mid-frame clears outputs and suppresses the strobe
    p0 = npulse;
    run_frame(1, 20 * H + 30, -1);
    idle(1);
    check("rstab_pulses", 32'(npulse - p0), 32'd0);
    check("rstab_row",    32'(oEdge_Row), 32'd0);
    check("rstab_col",    32'(oEdge_Col), 32'd0);
    check("rstab_found",  32'(oFound),    32'd0);
    run_frame(1, -1, -1);
    check("rstnext_row",  32'(oEdge_Row), 32'(RECT_ROW));
    check("rstnext_col",  32'(oEdge_Col), 32'(RECT_COL));
    idle(1);

    // en low for one cycle mid-frame: outputs keep the line-frame result
    run_frame(3, -1, -1);
    idle(1);
    p0 = npulse;
    run_frame(1, -1, 20 * H + 30);
    check("enab_valid",  32'(oValid),    32'd0);
    idle(1);
    check("enab_pulses", 32'(npulse - p0), 32'd0);
    check("enab_row",    32'(oEdge_Row), 32'(LINE_ROW));
    check("enab_col",    32'(oEdge_Col), 32'(LINE_COL));

    // back-to-back frames: second (0,0) lands in the DONE cycle
    p0 = npulse;
    run_frame(3, -1, -1);
    run_frame(1, -1, -1);
    check("b2b_valid",   32'(oValid),    32'd1);
    check("b2b_row",     32'(oEdge_Row), 32'(RECT_ROW));
    idle(2);
    check("b2b_pulses",  32'(npulse - p0), 32'd2);
    check("b2b_gap",     32'(vcyc_last - vcyc_prev), 32'(FRAME));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
